// File: rtl/shim_pkg.sv
// Constants and state encoding shared by the absolute-sample collector and
// the threshold integrator that consumes its bus.
package shim_pkg;

    localparam int unsigned SHIM_N_CH         = 8;
    localparam int unsigned SHIM_IN_WIDTH     = 16;
    localparam int unsigned SHIM_ABS_WIDTH    = 15;
    localparam int unsigned SHIM_CONCAT_WIDTH = SHIM_N_CH * SHIM_ABS_WIDTH;
    localparam int unsigned SHIM_STALE_LIMIT  = 64;
    localparam int unsigned SHIM_STALE_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } collector_state_e;

endpackage

// File: rtl/shim_abs_sample_collector_if.sv
// Serial per-channel sample bus from the ADC/DAC sample core to the collector.
interface shim_abs_sample_collector_if #(
    parameter int unsigned IN_WIDTH = 16
);
    logic                sample_valid;
    logic [2:0]          sample_channel;
    logic [IN_WIDTH-1:0] sample_data;

    modport master (output sample_valid, output sample_channel, output sample_data);
    modport slave  (input  sample_valid, input  sample_channel, input  sample_data);
endinterface

// File: rtl/shim_abs_sat.sv
// Signed sample to unsigned magnitude; values that do not fit in ABS_WIDTH
// (only the most negative input at the default widths) clamp to all-ones.
module shim_abs_sat #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned ABS_WIDTH = 15
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [ABS_WIDTH-1:0] mag
);
    logic [IN_WIDTH-1:0] abs_full;

    always_comb begin
        abs_full = din[IN_WIDTH-1] ? (~din + 1'b1) : din;
        if (abs_full[IN_WIDTH-1:ABS_WIDTH] != '0) begin
            mag = '1;
        end else begin
            mag = abs_full[ABS_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/shim_abs_sample_collector.sv
// Gathers serial per-channel samples into a shadow frame and commits all
// channel magnitudes atomically once every channel has been written.
module shim_abs_sample_collector
    import shim_pkg::*;
#(
    parameter int unsigned N_CH        = SHIM_N_CH,
    parameter int unsigned IN_WIDTH    = SHIM_IN_WIDTH,
    parameter int unsigned ABS_WIDTH   = SHIM_ABS_WIDTH,
    parameter int unsigned STALE_LIMIT = SHIM_STALE_LIMIT,
    parameter int unsigned STALE_W     = SHIM_STALE_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    shim_abs_sample_collector_if.slave  smp,
    output logic [N_CH*ABS_WIDTH-1:0]   abs_sample_concat,
    output logic                        concat_update,
    output logic                        sample_core_done,
    output logic                        err_dup,
    output logic                        err_stale
);
    collector_state_e     state_q, state_d;
    logic [N_CH-1:0]      mask_q;
    logic [STALE_W-1:0]   stale_q;
    logic [ABS_WIDTH-1:0] shadow_q [N_CH];
    logic [ABS_WIDTH-1:0] mag;

    logic            active, ch_ok, accept, commit, dup, stale_hit, err_any, leave_run;
    logic [N_CH-1:0] ch_onehot;

    shim_abs_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .ABS_WIDTH (ABS_WIDTH)
    ) u_abs_sat (
        .din (smp.sample_data),
        .mag (mag)
    );

    always_comb begin
        ch_ok     = int'(smp.sample_channel) < int'(N_CH);
        ch_onehot = '0;
        if (ch_ok) ch_onehot[smp.sample_channel] = 1'b1;

        active    = enable && (state_q == ST_PRIME || state_q == ST_RUN);
        leave_run = !enable && (state_q == ST_PRIME || state_q == ST_RUN);
        commit    = active && (mask_q == '1);
        accept    = active && smp.sample_valid && ch_ok;
        // The commit edge starts a fresh frame, so a repeated channel there is legal.
        dup       = accept && !commit && ((mask_q & ch_onehot) != '0);
        stale_hit = active && !commit && (mask_q != '0) &&
                    (stale_q == STALE_W'(STALE_LIMIT - 1));
        err_any   = dup || stale_hit;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PRIME;
            ST_PRIME: begin
                if (err_any)      state_d = ST_ERROR;
                else if (!enable) state_d = ST_IDLE;
                else if (commit)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (err_any)      state_d = ST_ERROR;
                else if (!enable) state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_q            <= '0;
            stale_q           <= '0;
            abs_sample_concat <= '0;
            concat_update     <= 1'b0;
            sample_core_done  <= 1'b0;
            err_dup           <= 1'b0;
            err_stale         <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) shadow_q[i] <= '0;
        end else begin
            concat_update <= commit;
            if (commit) begin
                for (int unsigned i = 0; i < N_CH; i++)
                    abs_sample_concat[i*ABS_WIDTH +: ABS_WIDTH] <= shadow_q[i];
                if (state_q == ST_PRIME) sample_core_done <= 1'b1;
            end
            if (dup)       err_dup   <= 1'b1;
            if (stale_hit) err_stale <= 1'b1;

            if (state_q == ST_IDLE || leave_run) begin
                mask_q           <= '0;
                stale_q          <= '0;
                sample_core_done <= 1'b0;
            end else if (active && !err_any) begin
                if (accept) shadow_q[smp.sample_channel] <= mag;
                mask_q <= (commit ? '0 : mask_q) | (accept ? ch_onehot : '0);
                if (commit)              stale_q <= '0;
                else if (mask_q != '0)   stale_q <= stale_q + 1'b1;
            end
        end
    end
endmodule
